// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier, two multiplier bits retired per cycle, valid/ready on both sides.
// Optional macro BOOTH_MULT_ZERO_SKIP_EN: a zero operand bypasses the iteration and completes in one edge.
module booth_radix4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 op_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int N  = WIDTH / 2 + 1;
  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 2;
  localparam int CW = $clog2(N + 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_radix4_seq_mult: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [AW-1:0]   m_q, m_d;
  logic [EW-1:0]          b_q, b_d;
  logic                   prev_q, prev_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     product_q, product_d;

  logic signed [AW-1:0]   a_ext;
  logic [EW-1:0]          b_ext;
  logic signed [AW-1:0]   pp;
  logic                   zero_skip;

  function automatic logic signed [AW-1:0] booth_pp(input logic [2:0] trip,
                                                    input logic signed [AW-1:0] m);
    case (trip)
      3'b001, 3'b010: booth_pp = m;
      3'b011:         booth_pp = m <<< 1;
      3'b100:         booth_pp = -(m <<< 1);
      3'b101, 3'b110: booth_pp = -m;
      default:        booth_pp = '0;
    endcase
  endfunction

  assign a_ext = {{(AW-WIDTH){op_signed & a[WIDTH-1]}}, a};
  assign b_ext = {{2{op_signed & b[WIDTH-1]}}, b};

`ifdef BOOTH_MULT_ZERO_SKIP_EN
  assign zero_skip = (a == '0) || (b == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // m_q is pre-shifted by 4^i and b_q shifted right, so the triplet always sits at the bottom.
  assign pp = booth_pp({b_q[1:0], prev_q}, m_q);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    m_d       = m_q;
    b_d       = b_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d  = '0;
          cnt_d  = '0;
          m_d    = a_ext;
          b_d    = b_ext;
          prev_d = 1'b0;
          if (zero_skip) begin
            product_d = '0;
            state_d   = DONE;
          end else begin
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d  = acc_q + pp;
        m_d    = m_q <<< 2;
        b_d    = {2'b00, b_q[EW-1:2]};
        prev_d = b_q[1];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          product_d = acc_d[2*WIDTH-1:0];
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      m_q       <= '0;
      b_q       <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      b_q       <= b_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

endmodule

// File: doc/booth_radix4_seq_mult.md
Name: booth_radix4_seq_mult

Overview:
Sequential, parametrised radix-4 Booth multiplier. It is the clocked successor of the team's combinational radix-2 Booth multiplier. It retires 2 multiplier bits per cycle and supports signed and unsigned operands, selected per operation. It sits behind a valid/ready handshake on both input and output, so it drops into pipelined datapaths without combinational multiply depth.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4 (elaboration error otherwise).

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
op_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b
out_valid  output  1  product valid
out_ready  input  1  consumer takes product
product  output  2*WIDTH  result; signed or unsigned per captured op_signed
busy  output  1  iteration in progress

Behaviour:
- Reset (async, rst_n low): state IDLE, in_ready=1, out_valid=0, busy=0, product=0, internal accumulator/counter cleared.
- Reset mid-operation: aborts immediately. No product is emitted. The block returns to IDLE.
- Constants: N = WIDTH/2 + 1 iterations. EW = WIDTH+2 is the extended operand width.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, capture a and b, each extended to EW bits. The extension is sign-extension if op_signed=1, zero-extension if op_signed=0. Clear the accumulator and count. Go to BUSY.
  - BUSY: busy=1, in_ready=0. Each cycle:
    - examine multiplier triplet {b_ext[2i+1], b_ext[2i], b_ext[2i-1]}, with b_ext[-1]=0;
    - add 0, +M, +2M, -2M, -M or -0 (standard radix-4 encoding) times 4^i to the accumulator;
    - arithmetic is 2*WIDTH+2 bits wide, two's complement, wrap-free by construction.
  - After the N-th iteration: go to DONE and register product as the low 2*WIDTH bits of the accumulator.
  - DONE: out_valid=1, product stable. On out_ready go to IDLE, and out_valid drops on that edge.
  - in_ready stays 0 in DONE; no overlap of operations.
- Latency: out_valid rises exactly N clock edges after the accept edge (WIDTH=8: 5). Throughput is one op per N+2 cycles with out_ready tied high.
- Back-pressure: product and out_valid hold indefinitely while out_ready=0.
- in_valid while not in IDLE is ignored. a, b and op_signed may change freely after the accept edge.
- Boundaries:
  - Signed most-negative times most-negative is exact, e.g. WIDTH=8: -128*-128 = 16384.
  - Unsigned all-ones is exact: 255*255 = 65025.
  - A zero operand yields 0 after the normal N cycles, unless the optional feature is enabled.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
BOOTH_MULT_ZERO_SKIP_EN
- Defined: if a==0 or b==0 at the accept edge, go directly from IDLE to DONE. product=0 and out_valid rises 1 edge after accept; busy never asserts.
- Undefined: no special case; all operations take N cycles.
- Product values are identical either way.

Test Plan:
- WIDTH=8, op_signed=1, a=-128, b=-128, out_ready=1 -> out_valid exactly 5 edges after accept, product=16'h4000; busy high for those 5 cycles.
- WIDTH=8, op_signed=0, a=8'hFF, b=8'hFF -> product=16'hFE01. Then same operands with op_signed=1 -> product=16'h0001.
- WIDTH=8, signed a=7, b=-3; hold out_ready=0 for 10 cycles -> out_valid stays 1, product=16'hFFEB stable, in_ready=0 throughout. Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Assert rst_n low during BUSY iteration 3 -> all outputs return to reset values asynchronously. A fresh op after release (a=5, b=6) -> product=30.
- a=0, b=-1 signed -> product=0; 1-edge latency with BOOTH_MULT_ZERO_SKIP_EN, 5-edge latency without.
- Random sweep, WIDTH=8 and WIDTH=16, 10k ops each, random op_signed, in_valid and out_ready -> every product matches the reference model. Exactly one output per accepted input, in order.
